matrix_b_stream_reader: RTL

//  Read-side sequencer for the 16x3 synchronous matrix-B RAM: on START it walks LENGTH

---
 rtl/matrix_b_stream_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/matrix_b_stream_reader.sv
// matrix_b_stream_reader
//   Read-side sequencer for the matrix-B RAM. A START pulse walks LENGTH
//   consecutive addresses from BASE_ADDR, wrapping at the top of the address
//   space. The words come out on a valid/ready stream. A 2-entry buffer hides
//   the RAM's one-cycle read latency and absorbs consumer back-pressure.
//
// Ports
//   CLK, RST            rising-edge clock, asynchronous active-low reset
//   START               one-cycle burst request; ignored unless idle
//   BASE_ADDR, LENGTH   burst start address and word count (0..2**ADDR_W)
//   ADDRESS_B           registered RAM read address
//   Write_EN_B          RAM write enable, tied low (read-only client)
//   RAM_OUT             RAM read data, one edge after ADDRESS_B is sampled
//   DATA_OUT/VALID      stream word (buffer head) and its valid flag
//   DATA_READY          consumer accept; a transfer is VALID & READY at an edge
//   BUSY                burst in progress
//   DONE                one-cycle completion pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for START
// ISSUE  | issuing RAM reads while buffer space allows
// DRAIN  | all reads issued, waiting for the remaining transfers
// FINISH | DONE pulse for one cycle, then back to IDLE
module matrix_b_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LENGTH,
  output logic [ADDR_W-1:0] ADDRESS_B,
  output logic              Write_EN_B,
  input  logic [DATA_W-1:0] RAM_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [1:0]        state;
  logic [ADDR_W:0]   rem_issue;
  logic [ADDR_W:0]   rem_xfer;
  logic              in_flight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf_head;
  logic [DATA_W-1:0] buf_tail;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_after;

  assign pop        = DATA_VALID & DATA_READY;
  // Occupancy once this edge's capture and pop have happened. A new read is
  // issued only if its word will still fit when it lands one edge later.
  assign occ_after  = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign issue      = (state == S_ISSUE) && (rem_issue != '0) && (occ_after < 3'd2);

  assign DATA_VALID = (occ != 2'd0);
  assign DATA_OUT   = buf_head;
  assign BUSY       = (state == S_ISSUE) || (state == S_DRAIN);
  assign DONE       = (state == S_FINISH);
  assign Write_EN_B = 1'b0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      ADDRESS_B <= '0;
      rem_issue <= '0;
      rem_xfer  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        rem_issue <= rem_issue - CNT_ONE;
        ADDRESS_B <= ADDRESS_B + ADDR_ONE;
      end
      if (pop && (rem_xfer != '0)) begin
        rem_xfer <= rem_xfer - CNT_ONE;
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            if (LENGTH != '0) begin
              state     <= S_ISSUE;
              ADDRESS_B <= BASE_ADDR;
              rem_issue <= LENGTH;
              rem_xfer  <= LENGTH;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          if (pop && (rem_xfer == CNT_ONE)) begin
            state <= S_FINISH;
          end else if (issue && (rem_issue == CNT_ONE)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (rem_xfer == CNT_ONE)) begin
            state <= S_FINISH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO: buf_head is the stream head, buf_tail the second word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({in_flight, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= RAM_OUT;
          else             buf_tail <= RAM_OUT;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= RAM_OUT;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= RAM_OUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
